// File: rtl/key_counter_arbiter.sv
// Two-digit BCD up/down counter shared by two requesters through a round-robin
// arbiter, with optional grant spacing and a sticky overload state.
module key_counter_arbiter #(
  parameter int unsigned MIN_GAP  = 0,
  parameter logic [3:0]  OVF_CODE = 4'd14
) (
  input  logic       clk100_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic [1:0] req_i,
  input  logic [1:0] op_i,
  output logic [1:0] ack_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit0_o,
  output logic       ovf_o,
  output logic       busy_o
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  // Handshake: req_i[n] is a level held until ack_o[n] pulses for one cycle;
  // the requester drops or changes req/op by the edge after seeing that ack.
  logic [1:0]       ack_q, ack_d;
  logic [3:0]       digit1_q, digit1_d;
  logic [3:0]       digit0_q, digit0_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [1:0] elig;
  logic       grant_vld;
  logic       grant_id;
  logic       op_dec;

  assign elig = req_i & ~ack_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!clear_i && (gap_q == '0)) begin
      case (elig)
        2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;    end
        2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;    end
        2'b11:   begin grant_vld = 1'b1; grant_id = ~last_q; end
        default: begin grant_vld = 1'b0; grant_id = 1'b0;    end
      endcase
    end
  end

  assign op_dec = op_i[grant_id];

  always_comb begin
    digit1_d = digit1_q;
    digit0_d = digit0_q;
    ovf_d    = ovf_q;
    ack_d    = grant_vld ? (2'b01 << grant_id) : 2'b00;
    last_d   = grant_vld ? grant_id : last_q;
    gap_d    = gap_q;
    if (clear_i) begin
      digit1_d = 4'd0;
      digit0_d = 4'd0;
      ovf_d    = 1'b0;
      gap_d    = '0;
    end else begin
      if (grant_vld)
        gap_d = GAP_LOAD;
      else if (gap_q != '0)
        gap_d = gap_q - GAP_W'(1);
      // Overload freezes the value; grants still ack and load the gap.
      if (grant_vld && !ovf_q) begin
        if (!op_dec) begin
          if (digit0_q != 4'd9) begin
            digit0_d = digit0_q + 4'd1;
          end else if (digit1_q != 4'd9) begin
            digit0_d = 4'd0;
            digit1_d = digit1_q + 4'd1;
          end else begin
            ovf_d    = 1'b1;
            digit1_d = OVF_CODE;
            digit0_d = OVF_CODE;
          end
        end else begin
          if (digit0_q != 4'd0) begin
            digit0_d = digit0_q - 4'd1;
          end else if (digit1_q != 4'd0) begin
            digit0_d = 4'd9;
            digit1_d = digit1_q - 4'd1;
          end else begin
            ovf_d    = 1'b1;
            digit1_d = OVF_CODE;
            digit0_d = OVF_CODE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      ack_q    <= 2'b00;
      digit1_q <= 4'd0;
      digit0_q <= 4'd0;
      ovf_q    <= 1'b0;
      last_q   <= 1'b1;
      gap_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      digit1_q <= digit1_d;
      digit0_q <= digit0_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      gap_q    <= gap_d;
    end
  end

  assign ack_o    = ack_q;
  assign digit1_o = digit1_q;
  assign digit0_o = digit0_q;
  assign ovf_o    = ovf_q;
  assign busy_o   = (gap_q != '0);

endmodule

// File: tb/tb_key_counter_arbiter.sv
// Directed bench for key_counter_arbiter: one instance with no grant gap and
// one with a gap of 3, checked through expected-value queues.
module tb_key_counter_arbiter;

  logic       clk;
  logic       rst_i;
  logic       clear_i, clear_g;
  logic [1:0] req_i, req_g;
  logic [1:0] op_i, op_g;
  logic [1:0] ack_o, ack_g;
  logic [3:0] digit1_o, digit0_o, digit1_g, digit0_g;
  logic       ovf_o, busy_o, ovf_g, busy_g;

  logic [11:0] exp_q[$];
  logic [11:0] exp_g_q[$];
  int compared = 0;
  int mismatched = 0;

  int  model_v = 0;
  logic model_ovf = 1'b0;

  key_counter_arbiter #(.MIN_GAP(0), .OVF_CODE(4'd14)) dut (
    .clk100_i(clk), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i), .op_i(op_i),
    .ack_o(ack_o), .digit1_o(digit1_o), .digit0_o(digit0_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  key_counter_arbiter #(.MIN_GAP(3), .OVF_CODE(4'd14)) dut_g (
    .clk100_i(clk), .rst_i(rst_i), .clear_i(clear_g), .req_i(req_g), .op_i(op_g),
    .ack_o(ack_g), .digit1_o(digit1_g), .digit0_o(digit0_g), .ovf_o(ovf_g), .busy_o(busy_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic [1:0] ack, input logic [3:0] d1,
                                       input logic [3:0] d0, input logic ovf, input logic busy);
    return {ack, d1, d0, ovf, busy};
  endfunction

  function automatic logic [11:0] model_exp(input logic [1:0] ack);
    logic [3:0] d1, d0;
    d1 = model_ovf ? 4'd14 : 4'(model_v / 10);
    d0 = model_ovf ? 4'd14 : 4'(model_v % 10);
    return pack(ack, d1, d0, model_ovf, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {ack,d1,d0,ovf,busy}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic clr,
                      input logic [1:0] req, input logic [1:0] op, input logic [11:0] exp);
    @(negedge clk);
    rst_i = rst; clear_i = clr; req_i = req; op_i = op;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check(tag, {ack_o, digit1_o, digit0_o, ovf_o, busy_o}, exp_q.pop_front());
  endtask

  // One granted operation followed by an idle cycle with the request dropped.
  task automatic do_op(input string tag, input int n, input logic dec);
    if (!model_ovf) begin
      if (!dec) begin
        if (model_v == 99) model_ovf = 1'b1; else model_v++;
      end else begin
        if (model_v == 0) model_ovf = 1'b1; else model_v--;
      end
    end
    step(tag, 1'b0, 1'b0, 2'(1 << n), 2'(dec) << n, model_exp(2'(1 << n)));
    step({tag, "_idle"}, 1'b0, 1'b0, 2'b00, 2'b00, model_exp(2'b00));
  endtask

  task automatic step_g(input string tag, input logic rst, input logic [1:0] req,
                        input logic [11:0] exp);
    @(negedge clk);
    rst_i = rst; clear_g = 1'b0; req_g = req; op_g = 2'b00;
    exp_g_q.push_back(exp);
    @(posedge clk); #1;
    check(tag, {ack_g, digit1_g, digit0_g, ovf_g, busy_g}, exp_g_q.pop_front());
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_i = 2'b00; op_i = 2'b00;
    clear_g = 1'b0; req_g = 2'b00; op_g = 2'b00;

    // Reset dominates clear and an eligible request.
    step("reset", 1'b1, 1'b1, 2'b11, 2'b00, pack(2'b00, 4'd0, 4'd0, 1'b0, 1'b0));
    model_v = 0; model_ovf = 1'b0;

    do_op("first_inc", 0, 1'b0);
    for (int i = 0; i < 8; i++) do_op("inc_to_9", i % 2, 1'b0);
    do_op("carry_up_10", 1, 1'b0);
    do_op("borrow_down_09", 0, 1'b1);
    for (int i = 0; i < 90; i++) do_op("inc_to_99", $urandom_range(0, 1), 1'b0);
    do_op("overflow_99", 0, 1'b0);
    do_op("ovf_hold_inc", 1, 1'b0);
    do_op("ovf_hold_dec", 0, 1'b1);

    // Clear with a pending decrement at 00: clear wins, no ack, no overload.
    model_v = 0; model_ovf = 1'b0;
    step("clear_ovf", 1'b0, 1'b1, 2'b01, 2'b01, model_exp(2'b00));
    do_op("underflow_00", 0, 1'b1);
    model_v = 0; model_ovf = 1'b0;
    step("clear_pulse", 1'b0, 1'b1, 2'b00, 2'b00, model_exp(2'b00));

    // Clear blocks the grant for that edge only.
    step("clear_collide", 1'b0, 1'b1, 2'b10, 2'b00, model_exp(2'b00));
    model_v = 1;
    step("after_clear_ack", 1'b0, 1'b0, 2'b10, 2'b00, model_exp(2'b10));
    step("after_clear_idle", 1'b0, 1'b0, 2'b00, 2'b00, model_exp(2'b00));

    // Fairness from reset with both requesters held.
    step("reset_fair", 1'b1, 1'b0, 2'b11, 2'b00, pack(2'b00, 4'd0, 4'd0, 1'b0, 1'b0));
    step("fair_0", 1'b0, 1'b0, 2'b11, 2'b00, pack(2'b01, 4'd0, 4'd1, 1'b0, 1'b0));
    step("fair_1", 1'b0, 1'b0, 2'b11, 2'b00, pack(2'b10, 4'd0, 4'd2, 1'b0, 1'b0));
    step("fair_2", 1'b0, 1'b0, 2'b11, 2'b00, pack(2'b01, 4'd0, 4'd3, 1'b0, 1'b0));
    step("fair_3", 1'b0, 1'b0, 2'b11, 2'b00, pack(2'b10, 4'd0, 4'd4, 1'b0, 1'b0));
    step("fair_idle", 1'b0, 1'b0, 2'b00, 2'b00, pack(2'b00, 4'd0, 4'd4, 1'b0, 1'b0));

    // Gap-3 instance: acks every 4 cycles, alternating, busy for 3 cycles.
    step_g("gap_reset", 1'b1, 2'b11, pack(2'b00, 4'd0, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) begin
      logic [1:0] ea;
      ea = (i % 4 != 0) ? 2'b00 : (((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
      step_g("gap_seq", 1'b0, 2'b11, pack(ea, 4'd0, 4'(i / 4 + 1), 1'b0, (i % 4) != 3));
    end
    step_g("gap_reset_mid", 1'b1, 2'b11, pack(2'b00, 4'd0, 4'd0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
